instr_loader: RTL and testbench

Host-facing program loader that sits directly upstream of the control unit. It accepts a length-prefixed instruction byte stream from the host pins over a valid/ready handshake. For each instruction byte it generates the instruction-memory write strobe (fetch_ins), the write data (ui_out) and the write address (dma_address). After the last byte is written it issues a single-cycle start pulse to launch execution.

---
 rtl/instr_loader.sv | 114 +++++++++++
 tb/tb_instr_loader.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// instr_loader: length-prefixed host byte stream to instruction-memory writes, then a start pulse.
// Define CHECKSUM_EN to require a trailing XOR checksum byte before start.
module instr_loader #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [7:0]        host_data,
  input  logic              host_valid,
  output logic              host_ready,
  output logic              fetch_ins,
  output logic [7:0]        ui_out,
  output logic [ADDR_W-1:0] dma_address,
  output logic              start,
  output logic              busy,
  output logic              done,
  output logic              error
);
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic [2:0] {
    IDLE, HEADER, PAYLOAD,
`ifdef CHECKSUM_EN
    CHECK,
`endif
    START, DONE, ERROR
  } state_t;
  state_t            state_q;
  logic [CW-1:0]     cnt_q, len_q, cnt_d;
  logic [7:0]        ui_q;
  logic [ADDR_W-1:0] addr_q;
  logic              fetch_q, start_q, done_q, error_q, xfer, last;
`ifdef CHECKSUM_EN
  logic [7:0]        csum_q;
  assign host_ready = state_q == HEADER || state_q == PAYLOAD || state_q == CHECK;
`else
  assign host_ready = state_q == HEADER || state_q == PAYLOAD;
`endif
  assign busy        = host_ready || state_q == START;
  assign xfer        = host_valid && host_ready;
  assign cnt_d       = cnt_q + CW'(1);
  assign last        = cnt_d == len_q;
  assign fetch_ins   = fetch_q;
  assign ui_out      = ui_q;
  assign dma_address = addr_q;
  assign start       = start_q;
  assign done        = done_q;
  assign error       = error_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      ui_q    <= '0;
      addr_q  <= '0;
      fetch_q <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
`ifdef CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      fetch_q <= 1'b0;
      start_q <= 1'b0;
      case (state_q)
        IDLE: if (load_en) state_q <= HEADER;
        HEADER: if (xfer) begin
          if (host_data == 0 || 32'(host_data) > DEPTH) begin
            state_q <= ERROR;
            error_q <= 1'b1;
          end else begin
            len_q   <= CW'(host_data);
            cnt_q   <= '0;
            state_q <= PAYLOAD;
`ifdef CHECKSUM_EN
            csum_q  <= host_data;
`endif
          end
        end
        PAYLOAD: if (xfer) begin
          ui_q    <= host_data;
          addr_q  <= ADDR_W'(cnt_q);
          fetch_q <= 1'b1;
          cnt_q   <= cnt_d;
`ifdef CHECKSUM_EN
          csum_q  <= csum_q ^ host_data;
          if (last) state_q <= CHECK;
`else
          if (last) state_q <= START;
`endif
        end
`ifdef CHECKSUM_EN
        CHECK: if (xfer) begin
          state_q <= host_data == csum_q ? START : ERROR;
          error_q <= host_data != csum_q;
        end
`endif
        START: begin
          start_q <= 1'b1;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE, ERROR: if (load_en) begin
          state_q <= HEADER;
          done_q  <= 1'b0;
          error_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: directed vector table plus hand sequences for instr_loader.
module tb_instr_loader;
  logic       clk = 1'b0, reset = 1'b1, load_en = 1'b0, host_valid = 1'b0;
  logic [7:0] host_data = 8'h00;
  logic       host_ready, fetch_ins, start, busy, done, error;
  logic [7:0] ui_out;
  logic [3:0] dma_address;
  int checks = 0, errors = 0;

  instr_loader #(.ADDR_W(4), .DEPTH(10)) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .host_data(host_data),
    .host_valid(host_valid), .host_ready(host_ready), .fetch_ins(fetch_ins),
    .ui_out(ui_out), .dma_address(dma_address), .start(start), .busy(busy),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic le, hv; logic [7:0] hd;
    logic rdy, bsy, fi; logic [7:0] ui; logic [3:0] a; logic st, dn, er;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic cyc(input logic le, input logic hv, input logic [7:0] hd);
    load_en = le; host_valid = hv; host_data = hd;
    @(posedge clk); #1;
    load_en = 1'b0; host_valid = 1'b0;
  endtask

  task automatic chk_write(input string n, input logic [3:0] a, input logic [7:0] d);
    chk({n, " fetch"}, fetch_ins, 1);
    chk({n, " addr"}, dma_address, a);
    chk({n, " data"}, ui_out, d);
  endtask

  task automatic chk_all_zero(input string n);
    chk({n, " fetch"}, fetch_ins, 0);
    chk({n, " ui"}, ui_out, 0);
    chk({n, " addr"}, dma_address, 0);
    chk({n, " start"}, start, 0);
    chk({n, " done"}, done, 0);
    chk({n, " error"}, error, 0);
    chk({n, " busy"}, busy, 0);
    chk({n, " ready"}, host_ready, 0);
  endtask

  initial begin
    logic [7:0] c;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;
`ifndef CHECKSUM_EN
    //             le hv hd     rdy bsy fi ui     a  st dn er
    vecs.push_back('{1, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0, 0, 0});
    vecs.push_back('{0, 1, 8'h03, 1, 1, 0, 8'h00, 0, 0, 0, 0});
    vecs.push_back('{0, 1, 8'h21, 1, 1, 1, 8'h21, 0, 0, 0, 0});
    vecs.push_back('{0, 1, 8'h40, 1, 1, 1, 8'h40, 1, 0, 0, 0});
    vecs.push_back('{0, 1, 8'h80, 0, 1, 1, 8'h80, 2, 0, 0, 0});
    vecs.push_back('{0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 1, 0});
    vecs.push_back('{0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1, 0});
    vecs.push_back('{1, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0, 0, 0});
    vecs.push_back('{0, 1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 1});
    vecs.push_back('{0, 1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 1});
    vecs.push_back('{1, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0, 0, 0});
    vecs.push_back('{0, 1, 8'h0B, 0, 0, 0, 8'h00, 0, 0, 0, 1});
    vecs.push_back('{1, 1, 8'h05, 1, 1, 0, 8'h00, 0, 0, 0, 0});
    vecs.push_back('{0, 1, 8'h01, 1, 1, 0, 8'h00, 0, 0, 0, 0});
    vecs.push_back('{0, 1, 8'h00, 0, 1, 1, 8'h00, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 1, 0});
    vecs.push_back('{0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1, 0});
    vecs.push_back('{1, 1, 8'h02, 1, 1, 0, 8'h00, 0, 0, 0, 0});
    vecs.push_back('{0, 1, 8'h02, 1, 1, 0, 8'h00, 0, 0, 0, 0});
    vecs.push_back('{0, 1, 8'h60, 1, 1, 1, 8'h60, 0, 0, 0, 0});
    vecs.push_back('{1, 0, 8'hFF, 1, 1, 0, 8'h00, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 8'hFF, 1, 1, 0, 8'h00, 0, 0, 0, 0});
    vecs.push_back('{1, 0, 8'hFF, 1, 1, 0, 8'h00, 0, 0, 0, 0});
    vecs.push_back('{0, 1, 8'hA0, 0, 1, 1, 8'hA0, 1, 0, 0, 0});
    vecs.push_back('{0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 1, 0});
    vecs.push_back('{0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1, 0});
    foreach (vecs[i]) begin
      cyc(vecs[i].le, vecs[i].hv, vecs[i].hd);
      chk($sformatf("v%0d ready", i), host_ready, vecs[i].rdy);
      chk($sformatf("v%0d busy", i), busy, vecs[i].bsy);
      chk($sformatf("v%0d fetch", i), fetch_ins, vecs[i].fi);
      chk($sformatf("v%0d start", i), start, vecs[i].st);
      chk($sformatf("v%0d done", i), done, vecs[i].dn);
      chk($sformatf("v%0d error", i), error, vecs[i].er);
      if (vecs[i].fi) begin
        chk($sformatf("v%0d ui", i), ui_out, vecs[i].ui);
        chk($sformatf("v%0d addr", i), dma_address, vecs[i].a);
      end
    end
`else
    // Good checksum: 0x02 ^ 0x21 ^ 0x40 = 0x63.
    cyc(1, 0, 8'h00);
    cyc(0, 1, 8'h02);
    cyc(0, 1, 8'h21); chk_write("cs w0", 0, 8'h21);
    cyc(0, 1, 8'h40); chk_write("cs w1", 1, 8'h40);
    chk("cs check ready", host_ready, 1);
    cyc(0, 1, 8'h63); chk("cs ok fetch", fetch_ins, 0);
    cyc(0, 0, 8'h00); chk("cs ok start", start, 1); chk("cs ok done", done, 1);
    cyc(1, 0, 8'h00);
    cyc(0, 1, 8'h02);
    cyc(0, 1, 8'h21); chk_write("cs bad w0", 0, 8'h21);
    cyc(0, 1, 8'h40); chk_write("cs bad w1", 1, 8'h40);
    cyc(0, 1, 8'h62); chk("cs bad error", error, 1); chk("cs bad start", start, 0);
    repeat (3) begin
      cyc(0, 0, 8'h00); chk("cs bad no start", start, 0); chk("cs bad error hold", error, 1);
    end
`endif
    // Longest legal program: addresses 0..9 back to back.
    cyc(1, 0, 8'h00);
    cyc(0, 1, 8'd10);
    c = 8'd10;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 8'h10 + 8'(i));
      c ^= 8'h10 + 8'(i);
      chk_write($sformatf("max w%0d", i), 4'(i), 8'h10 + 8'(i));
    end
`ifdef CHECKSUM_EN
    cyc(0, 1, c);
`else
    cyc(0, 0, 8'h00);
`endif
    if (!start) cyc(0, 0, 8'h00);
    chk("max start", start, 1);
    chk("max done", done, 1);
    // Asynchronous reset in the middle of a payload.
    cyc(1, 0, 8'h00);
    cyc(0, 1, 8'h04);
    cyc(0, 1, 8'hAA);
    cyc(0, 1, 8'hBB); chk_write("mid w1", 1, 8'hBB);
    #2 reset = 1'b1;
    #1 chk_all_zero("async reset");
    @(posedge clk); #1;
    reset = 1'b0;
    chk("post reset ready", host_ready, 0);
    cyc(1, 0, 8'h00);
    cyc(0, 1, 8'h01);
    cyc(0, 1, 8'h55); chk_write("restart w0", 0, 8'h55);
`ifdef CHECKSUM_EN
    cyc(0, 1, 8'h54);
`endif
    cyc(0, 0, 8'h00); chk("restart start", start, 1);
    cyc(0, 0, 8'h00); chk("restart start once", start, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
